// File: rtl/pose_pkg.sv
// Shared types and helpers for the pose smoother: FSM states, coordinate indices, EMA step.
package pose_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int NUM_COORDS  = 6;

  localparam logic [2:0] IDX_LH_X = 3'd0;
  localparam logic [2:0] IDX_LH_Y = 3'd1;
  localparam logic [2:0] IDX_HD_X = 3'd2;
  localparam logic [2:0] IDX_HD_Y = 3'd3;
  localparam logic [2:0] IDX_RH_X = 3'd4;
  localparam logic [2:0] IDX_RH_Y = 3'd5;

  typedef enum logic [1:0] {IDLE, LOAD, FILTER, PRESENT} state_t;

  // Signed arithmetic shift of the difference floors toward -inf; result stays between f and s.
  function automatic int ema_step(input int f, input int s, input int shift);
    int d;
    d = s - f;
    return f + (d >>> shift);
  endfunction

endpackage

// File: rtl/pose_ema.sv
// Combinational single-coordinate EMA: seeded passes the sample through, else f + (s-f)/2^shift.
module pose_ema
  import pose_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic [COORD_W-1:0] f,
  input  logic [COORD_W-1:0] s,
  input  logic               seed,
  output logic [COORD_W-1:0] out
);

  int step;

  always_comb begin
    step = ema_step(int'(f), int'(s), ALPHA_SHIFT);
  end

  assign out = seed ? s : COORD_W'(step);

endmodule

// File: rtl/pose_smoother.sv
// Snapshots three marker coordinates on each ready rising edge, EMA-smooths them one per cycle
// and presents the pose on a valid/ready handshake. Optional lost-track detection: POSE_LOST_DETECT_EN.
module pose_smoother
  import pose_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int ALPHA_SHIFT = 2,
  parameter int LOST_FRAMES = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFrame_Start,
  input  logic               iCoord_Ready,
  input  logic [COORD_W-1:0] iLH_X,
  input  logic [COORD_W-1:0] iLH_Y,
  input  logic [COORD_W-1:0] iHD_X,
  input  logic [COORD_W-1:0] iHD_Y,
  input  logic [COORD_W-1:0] iRH_X,
  input  logic [COORD_W-1:0] iRH_Y,
  output logic               oValid,
  input  logic               iReady,
  output logic [COORD_W-1:0] oLH_X,
  output logic [COORD_W-1:0] oLH_Y,
  output logic [COORD_W-1:0] oHD_X,
  output logic [COORD_W-1:0] oHD_Y,
  output logic [COORD_W-1:0] oRH_X,
  output logic [COORD_W-1:0] oRH_Y,
  output logic               oLost
);

  state_t             state;
  logic [2:0]         idx;
  logic               rdy_q;
  logic               pend;
  logic               seed;
  logic               valid;
  logic               lost;
  logic               rise;
  logic [COORD_W-1:0] raw    [NUM_COORDS];
  logic [COORD_W-1:0] snap   [NUM_COORDS];
  logic [COORD_W-1:0] work   [NUM_COORDS];
  logic [COORD_W-1:0] smooth [NUM_COORDS];
  logic [COORD_W-1:0] f_sel;
  logic [COORD_W-1:0] s_sel;
  logic [COORD_W-1:0] ema_out;

  assign rise = iCoord_Ready & ~rdy_q;

  always_comb begin
    raw[IDX_LH_X] = iLH_X;
    raw[IDX_LH_Y] = iLH_Y;
    raw[IDX_HD_X] = iHD_X;
    raw[IDX_HD_Y] = iHD_Y;
    raw[IDX_RH_X] = iRH_X;
    raw[IDX_RH_Y] = iRH_Y;
  end

  // One EMA datapath shared across the six FILTER cycles.
  always_comb begin
    f_sel = '0;
    s_sel = '0;
    for (int i = 0; i < NUM_COORDS; i++) begin
      if (idx == 3'(i)) begin
        f_sel = smooth[i];
        s_sel = work[i];
      end
    end
  end

  pose_ema #(
    .COORD_W    (COORD_W),
    .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_ema (
    .f   (f_sel),
    .s   (s_sel),
    .seed(seed),
    .out (ema_out)
  );

`ifdef POSE_LOST_DETECT_EN
  localparam int LOST_W = $clog2(LOST_FRAMES + 1);
  logic [LOST_W-1:0] lost_cnt;

  assign lost = (lost_cnt == LOST_W'(LOST_FRAMES));

  // Clear on LOAD takes priority over a coincident frame start.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      lost_cnt <= '0;
    end else if (state == LOAD) begin
      lost_cnt <= '0;
    end else if (iFrame_Start && !lost) begin
      lost_cnt <= lost_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = iFrame_Start ^ (LOST_FRAMES == 0);
  assign lost       = 1'b0;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      idx   <= '0;
      rdy_q <= 1'b0;
      pend  <= 1'b0;
      seed  <= 1'b1;
      valid <= 1'b0;
      for (int i = 0; i < NUM_COORDS; i++) begin
        snap[i]   <= '0;
        work[i]   <= '0;
        smooth[i] <= '0;
      end
    end else begin
      rdy_q <= iCoord_Ready;
      // A fresh edge always refreshes the snapshot, even in the LOAD cycle.
      if (rise) begin
        pend <= 1'b1;
        for (int i = 0; i < NUM_COORDS; i++) snap[i] <= raw[i];
      end else if (state == LOAD) begin
        pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pend) state <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < NUM_COORDS; i++) work[i] <= snap[i];
          idx   <= '0;
          state <= FILTER;
        end
        FILTER: begin
          for (int i = 0; i < NUM_COORDS; i++) begin
            if (idx == 3'(i)) smooth[i] <= ema_out;
          end
          if (idx == IDX_RH_Y) begin
            seed  <= 1'b0;
            valid <= 1'b1;
            state <= PRESENT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        PRESENT: begin
          if (iReady) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (lost) seed <= 1'b1;
    end
  end

  assign oValid = valid;
  assign oLH_X  = smooth[IDX_LH_X];
  assign oLH_Y  = smooth[IDX_LH_Y];
  assign oHD_X  = smooth[IDX_HD_X];
  assign oHD_Y  = smooth[IDX_HD_Y];
  assign oRH_X  = smooth[IDX_RH_X];
  assign oRH_Y  = smooth[IDX_RH_Y];
  assign oLost  = lost;

endmodule

// File: tb/tb_pose_smoother.sv
// Randomized bench for pose_smoother against a transaction-level EMA reference model.
module tb_pose_smoother;

  localparam int CW = 11;
  localparam int A  = 2;
  localparam int LF = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          coord_ready;
  logic          ready;
  logic          valid;
  logic          lost;
  logic [CW-1:0] in_c  [6];
  logic [CW-1:0] out_c [6];

  int n_chk  = 0;
  int n_fail = 0;
  int mf [6];
  bit mseed;

  always #5 clk = ~clk;

  pose_smoother #(.COORD_W(CW), .ALPHA_SHIFT(A), .LOST_FRAMES(LF)) dut (
    .iCLK(clk), .iRST(rst), .iFrame_Start(frame_start), .iCoord_Ready(coord_ready),
    .iLH_X(in_c[0]), .iLH_Y(in_c[1]), .iHD_X(in_c[2]), .iHD_Y(in_c[3]),
    .iRH_X(in_c[4]), .iRH_Y(in_c[5]),
    .oValid(valid), .iReady(ready),
    .oLH_X(out_c[0]), .oLH_Y(out_c[1]), .oHD_X(out_c[2]), .oHD_Y(out_c[3]),
    .oRH_X(out_c[4]), .oRH_Y(out_c[5]),
    .oLost(lost)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: new = old + floor((sample - old) / 2^A), or the sample itself when seeding.
  function automatic int ema_ref(input int f, input int s);
    int d, div, q;
    d   = s - f;
    div = 1 << A;
    q   = d / div;
    if ((d % div) != 0 && d < 0) q = q - 1;
    return f + q;
  endfunction

  task automatic model_pose(input int v[6], output int e[6]);
    for (int i = 0; i < 6; i++) begin
      e[i]  = mseed ? v[i] : ema_ref(mf[i], v[i]);
      mf[i] = e[i];
    end
    mseed = 1'b0;
  endtask

  task automatic rand_pose(output int v[6]);
    for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(1, (1 << CW) - 1));
  endtask

  task automatic drive(input int v[6]);
    for (int i = 0; i < 6; i++) in_c[i] = CW'(v[i]);
  endtask

  task automatic pulse(input int v[6]);
    drive(v);
    coord_ready = 1'b1;
    @(negedge clk);
    coord_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int start, output int lat);
    lat = start;
    while (!valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_seen"}, int'(valid), 1);
  endtask

  task automatic check_outs(input string tag, input int e[6]);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_c%0d", tag, i), int'(out_c[i]), e[i]);
  endtask

  task automatic no_pose(input string tag, input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk(tag, int'(seen), 0);
  endtask

  // Idle-start pose with iReady high: fixed latency, then a one-cycle valid pulse.
  task automatic run_pose(input string tag, input int v[6]);
    int lat;
    int e[6];
    pulse(v);
    wait_valid(tag, 1, lat);
    chk({tag, "_lat"}, lat, 9);
    model_pose(v, e);
    check_outs(tag, e);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(valid), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int v[6], w[6], b[6], e[6];
    int lat;

    rst = 1'b1; frame_start = 1'b0; coord_ready = 1'b0; ready = 1'b1;
    for (int i = 0; i < 6; i++) in_c[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_lost", int'(lost), 0);
    for (int i = 0; i < 6; i++) chk($sformatf("rst_c%0d", i), int'(out_c[i]), 0);
    rst = 1'b0;
    mseed = 1'b1;
    for (int i = 0; i < 6; i++) mf[i] = 0;
    repeat (2) @(negedge clk);

    // First pose passes through unfiltered, then the documented EMA steps.
    v = '{100, 50, 320, 20, 540, 50};
    run_pose("first", v);
    v[0] = 104;
    run_pose("second", v);
    chk("lhx_101", int'(out_c[0]), 101);
    v[0] = 100;
    run_pose("third", v);
    chk("lhx_100", int'(out_c[0]), 100);

    for (int n = 0; n < 16; n++) begin
      rand_pose(v);
      run_pose($sformatf("rnd%0d", n), v);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Stall in PRESENT for 20 cycles with two edges arriving; only the later one survives.
    ready = 1'b0;
    rand_pose(v); rand_pose(w); rand_pose(b);
    pulse(v);
    wait_valid("stall", 1, lat);
    chk("stall_lat", lat, 9);
    model_pose(v, e);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("stall_vld%0d", c), int'(valid), 1);
      check_outs($sformatf("stall%0d", c), e);
      if (c == 3) begin drive(w); coord_ready = 1'b1; end
      if (c == 8) begin drive(b); coord_ready = 1'b1; end
      if (c == 4 || c == 9) coord_ready = 1'b0;
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("stall_accept", int'(valid), 0);
    wait_valid("after_stall", 0, lat);
    model_pose(b, e);
    check_outs("after_stall", e);
    no_pose("stall_single", 30);

    // Edge sampled in the LOAD cycle: first pose completes, the new one follows.
    rand_pose(v); rand_pose(w);
    drive(v); coord_ready = 1'b1;
    @(negedge clk); coord_ready = 1'b0;
    @(negedge clk); drive(w); coord_ready = 1'b1;
    @(negedge clk); coord_ready = 1'b0;
    wait_valid("load_a", 3, lat);
    chk("load_a_lat", lat, 9);
    model_pose(v, e);
    check_outs("load_a", e);
    @(negedge clk);
    wait_valid("load_b", 0, lat);
    model_pose(w, e);
    check_outs("load_b", e);
    no_pose("load_single", 30);

    // Reset during FILTER idx 3 with a further snapshot pending.
    rand_pose(v); rand_pose(w);
    pulse(v);
    repeat (2) @(negedge clk);
    drive(w); coord_ready = 1'b1;
    @(negedge clk); coord_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(valid), 0);
    for (int i = 0; i < 6; i++) chk($sformatf("midrst_c%0d", i), int'(out_c[i]), 0);
    @(negedge clk);
    rst = 1'b0;
    mseed = 1'b1;
    for (int i = 0; i < 6; i++) mf[i] = 0;
    no_pose("midrst_discard", 30);
    rand_pose(v);
    run_pose("reseed", v);
    for (int i = 0; i < 6; i++) chk($sformatf("reseed_raw%0d", i), int'(out_c[i]), v[i]);

`ifdef POSE_LOST_DETECT_EN
    chk("lost_start", int'(lost), 0);
    for (int p = 1; p <= LF; p++) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      if (p == LF - 1) chk("lost_pre", int'(lost), 0);
    end
    chk("lost_set", int'(lost), 1);
    mseed = 1'b1;
    rand_pose(v);
    v[0] = 600;
    run_pose("lost_reseed", v);
    chk("lost_lhx", int'(out_c[0]), 600);
    chk("lost_clr", int'(lost), 0);
`else
    repeat (LF + 2) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
    end
    chk("lost_off", int'(lost), 0);
    rand_pose(v);
    run_pose("post_frames", v);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
